// File: rtl/prog_loader.sv
// UART-fed program loader: receives a framed, checksummed image and writes it into a
// 32x8 program store that the CPU reads combinationally; gates the CPU's run enable.
module prog_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT      = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic [4:0] cpu_addr,
   output logic [7:0] instr,
   output logic       cpu_run,
   output logic       busy,
   output logic       load_ok,
   output logic       load_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TIMEOUT - 1);
   localparam logic [7:0]       HDR     = 8'hA5;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {F_IDLE, F_COUNT, F_DATA, F_SUM, F_OK, F_ERR} fr_state_t;

   logic             rx_s1, rx_s2, rx_prev;
   rx_state_t        r_state, r_nxt;
   logic [CNT_W-1:0] r_cnt, r_cnt_nxt;
   logic [2:0]       r_bit, r_bit_nxt;
   logic [7:0]       r_shift, r_shift_nxt;
   logic             byte_valid, frame_error;

   fr_state_t        f_state, f_nxt;
   logic [5:0]       f_len;
   logic [4:0]       f_addr;
   logic [7:0]       f_sum;
   logic [TO_W-1:0]  idle_cnt;
   logic             timed_out, mem_we, in_frame;
   logic [7:0]       mem [32];

   // Receiver: synchroniser, bit timing and byte assembly
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
         r_state <= R_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         rx_s1   <= rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         r_state <= r_nxt;
         r_cnt   <= r_cnt_nxt;
         r_bit   <= r_bit_nxt;
         r_shift <= r_shift_nxt;
      end
   end

   always_comb begin
      r_nxt       = r_state;
      r_cnt_nxt   = r_cnt;
      r_bit_nxt   = r_bit;
      r_shift_nxt = r_shift;
      byte_valid  = 1'b0;
      frame_error = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (rx_prev && !rx_s2) begin
               r_nxt     = R_START;
               r_cnt_nxt = '0;
            end
         end
         R_START: begin
            if (r_cnt == HALF_M1) begin
               r_cnt_nxt = '0;
               r_bit_nxt = '0;
               r_nxt     = rx_s2 ? R_IDLE : R_DATA;
            end else begin
               r_cnt_nxt = r_cnt + 1'b1;
            end
         end
         R_DATA: begin
            if (r_cnt == FULL_M1) begin
               r_cnt_nxt   = '0;
               r_shift_nxt = {rx_s2, r_shift[7:1]};
               r_bit_nxt   = r_bit + 3'd1;
               if (r_bit == 3'd7) r_nxt = R_STOP;
            end else begin
               r_cnt_nxt = r_cnt + 1'b1;
            end
         end
         R_STOP: begin
            if (r_cnt == FULL_M1) begin
               r_cnt_nxt   = '0;
               r_nxt       = R_IDLE;
               byte_valid  = rx_s2;
               frame_error = !rx_s2;
            end else begin
               r_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: r_nxt = R_IDLE;
      endcase
   end

   // Frame sequencer: header, count, data, checksum
   assign in_frame  = (f_state == F_COUNT) || (f_state == F_DATA) || (f_state == F_SUM);
   assign timed_out = in_frame && !byte_valid && (idle_cnt == TO_M1);

   always_comb begin
      f_nxt  = f_state;
      mem_we = 1'b0;
      case (f_state)
         F_IDLE:  if (byte_valid && r_shift == HDR) f_nxt = F_COUNT;
         F_COUNT: begin
            if (frame_error || timed_out) f_nxt = F_ERR;
            else if (byte_valid)
               f_nxt = (r_shift == 8'd0 || r_shift > 8'd32) ? F_ERR : F_DATA;
         end
         F_DATA: begin
            if (frame_error || timed_out) f_nxt = F_ERR;
            else if (byte_valid) begin
               mem_we = 1'b1;
               if ({1'b0, f_addr} + 6'd1 == f_len) f_nxt = F_SUM;
            end
         end
         F_SUM: begin
            if (frame_error || timed_out) f_nxt = F_ERR;
            else if (byte_valid) f_nxt = (r_shift == f_sum) ? F_OK : F_ERR;
         end
         F_OK:    f_nxt = F_IDLE;
         F_ERR:   f_nxt = F_IDLE;
         default: f_nxt = F_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         f_state  <= F_IDLE;
         f_len    <= '0;
         f_addr   <= '0;
         f_sum    <= '0;
         idle_cnt <= '0;
         cpu_run  <= 1'b0;
         for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      end else begin
         f_state <= f_nxt;
         if (f_state == F_COUNT && byte_valid) begin
            f_len  <= r_shift[5:0];
            f_addr <= '0;
            f_sum  <= '0;
         end
         if (mem_we) begin
            mem[f_addr] <= r_shift;
            f_addr      <= f_addr + 5'd1;
            f_sum       <= f_sum + r_shift;
         end
         if (in_frame && !byte_valid) idle_cnt <= idle_cnt + 1'b1;
         else                         idle_cnt <= '0;
         // Run enable drops at the header and only returns on a verified checksum
         if (f_state == F_IDLE && byte_valid && r_shift == HDR) cpu_run <= 1'b0;
         else if (f_state == F_SUM && f_nxt == F_OK)            cpu_run <= 1'b1;
      end
   end

   assign instr    = mem[cpu_addr];
   assign busy     = (f_state != F_IDLE);
   assign load_ok  = (f_state == F_OK);
   assign load_err = (f_state == F_ERR);

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- UART-fed program loader. It is the writer side of the CPU's instruction-fetch interface.
- Receives a framed program image over a serial line and writes it into a 32x8 program store.
- The CPU fetches from that store through an asynchronous read port.
- Holds the CPU in reset (cpu_run=0) while a load is in progress or after a failed load. Releases it only after a checksum-verified load.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Must be >= 4.
- TIMEOUT, 2000000, clk cycles allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rxd  in  1  UART receive line; asynchronous; idle high.
- cpu_addr  in  5  CPU fetch address (program counter).
- instr  out  8  instruction byte at cpu_addr; combinational read of the store.
- cpu_run  out  1  1 = CPU may run; drives the CPU's active-low reset directly.
- busy  out  1  1 while the frame FSM is in any state other than F_IDLE.
- load_ok  out  1  one-cycle pulse when a frame's checksum matches.
- load_err  out  1  one-cycle pulse on any frame abort.

Behaviour:
- Reset (synchronous, active-high):
  - All 32 store entries = 0x00 (a NOP: register 0 moved to itself).
  - cpu_run=0, busy=0, load_ok=0, load_err=0.
  - RX FSM and frame FSM return to idle; checksum and address counters clear.
  - Reset mid-frame discards the frame; bytes already written are cleared by the same reset.
- rxd synchronisation: 2-flop synchroniser. All RX logic uses the synchronised signal.
- RX FSM, 8N1, LSB first:
  - R_IDLE: wait for a falling edge.
  - R_START: count CLKS_PER_BIT/2 cycles, then sample. If high, treat as a glitch and return to R_IDLE with no byte.
  - R_DATA: sample 8 bits, each CLKS_PER_BIT apart.
  - R_STOP: sample once more. If 1, assert byte_valid for one cycle with the byte. If 0, assert frame_error for one cycle and discard the byte.
  - Then back to R_IDLE. The falling edge for the next start bit is searched from R_IDLE only.
- Frame format: 0xA5, N (1..32), N data bytes, S. S = 8-bit modulo sum of the data bytes only.
- Frame FSM:
  - F_IDLE: bytes other than 0xA5 are ignored. On 0xA5: cpu_run<=0, go to F_COUNT.
  - F_COUNT: N==0 or N>32 -> F_ERR. Otherwise latch N, addr<=0, sum<=0, go to F_DATA.
  - F_DATA: for each byte, mem[addr]<=byte, sum<=sum+byte, addr<=addr+1. After the Nth byte, go to F_SUM. Entries at addresses >= N keep their previous contents.
  - F_SUM: S==sum -> F_OK. Otherwise -> F_ERR.
  - F_OK: load_ok=1 for one cycle, cpu_run<=1, go to F_IDLE.
  - F_ERR: load_err=1 for one cycle, cpu_run stays 0, go to F_IDLE.
- Timing of cpu_run and pulses:
  - cpu_run falls on the edge after the header's byte_valid.
  - cpu_run rises one cycle after S is accepted, coincident with load_ok.
- Other abort causes (both go to F_ERR):
  - A frame_error while busy. A frame_error in F_IDLE is ignored.
  - Inter-byte timeout: an idle counter runs in F_COUNT, F_DATA and F_SUM and resets on every byte_valid. Reaching TIMEOUT goes to F_ERR.
- cpu_run after errors: once a load has failed, cpu_run stays 0 until a later frame passes the checksum. Partially written entries remain in the store.
- A new 0xA5 arriving during F_DATA is treated as data, not as a restart.
- Read port:
  - instr = mem[cpu_addr], purely combinational.
  - A write to the addressed entry is visible on instr after the write edge.
  - Reads are always permitted, even while cpu_run=0.

Test Plan:
- Reset: assert reset 2 cycles -> cpu_run=0, busy=0, instr=0x00 for cpu_addr=0..31.
- Good load: frame A5 03 81 92 A0 B3 -> mem[0..2]=81,92,A0; mem[3]=00; exactly one load_ok pulse; cpu_run=1 one cycle after the stop bit of B3; busy low after.
- Bad checksum: A5 02 10 20 31 -> mem[0..1]=10,20; load_err pulse; load_ok never; cpu_run stays 0. A subsequent good frame A5 01 C5 C5 -> cpu_run=1.
- Bad count: A5 00, and A5 21 -> load_err after the count byte; store unchanged; state F_IDLE.
- Framing error and glitch:
  - Byte with stop bit forced 0 inside a frame -> load_err.
  - Half-bit low pulse on rxd in F_IDLE -> no byte, no pulse.
  - Garbage 00 FF 5A before A5 -> ignored.
- Timeout and mid-load reset:
  - A5 04 11 then silence for TIMEOUT+10 cycles -> load_err, cpu_run=0.
  - Repeat with reset asserted mid-bit -> all outputs at reset values; the next good frame loads correctly.
